fp_seq_mul: RTL and testbench
=============================

// Module: fp_seq_mul
// PURPOSE
//  Iterative (shift-add) floating-point multiplier built on fp_pkg::fp. Consumes two fp operands on a
//  start/done handshake and produces a packed fp product with status flags. It sits downstream of the
//  fp_pkg classifiers and upstream of the divider/result mux. The area-lean alternative to a
//  combinational multiplier: one significand bit per clock.
// PARAMETERS
//  MB    23                  mantissa bits (must match fp_pkg::MB)
//  EB    8                   exponent bits (must match fp_pkg::EB)
//  BIAS  2**(EB-1)-1         exponent bias (localparam)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  start      in   1      request; sampled only in IDLE
//  a, b       in   N      fp_pkg::fp operands, N=MB+EB+1; sampled with start
//  busy       out  1      state != IDLE
//  done       out  1      single-cycle pulse; result/flags valid from this cycle
//  result     out  N      fp product; held until the next accepted start
//  invalid    out  1      an operand had exponent all-ones (NaN/inf class)
//  overflow   out  1      biased exponent >= 2**EB-1
//  underflow  out  1      biased exponent <= 0, or a denormal operand was flushed
//  zero       out  1      result is signed zero
// BEHAVIOUR
//  - Design has one clock and async active-low reset rst_n. Reset forces: state=IDLE, busy=0, done=0,
//    result='0, all flags=0. Reset mid-operation aborts and discards; no done is issued.
//  - FSM IDLE->MULT->NORM->DONE->IDLE. A special-case operand takes IDLE->DONE directly.
//  - IDLE, start=1: latch sign=a.sign^b.sign. Significands are {1,mant} (MB+1 bits).
//    Exponent sum e = a.exp + b.exp - BIAS, held in EB+2-bit signed. Clear the 2MB+2-bit accumulator.
//    Load counter = MB+1. Clear flags.
//  - Special-case priority, evaluated at start:
//    1. Either exponent all-ones -> result={0,'1,1'b1,'0} (quiet NaN), invalid=1.
//    2. Either operand zero or denormal -> result={sign,'0,'0}, zero=1.
//       The denormal case also sets underflow=1 (flush-to-zero).
//  - MULT: each cycle, if multiplier LSB=1 add the multiplicand to the accumulator upper half,
//    then shift right 1. Counter decrements; leave on counter==1 (exactly MB+1 cycles).
//  - NORM (1 cycle): if product bit 2MB+1 is set, take the mantissa from bits [2MB:MB+1] and e+=1.
//    Otherwise take bits [2MB-1:MB]. Round per CONFIGURATION.
//    Then: e >= 2**EB-1 -> result={sign,'1,'0}, overflow=1.
//          e <= 0 -> signed zero, underflow=1, zero=1.
//  - DONE: done=1 for exactly one cycle; result/flags registered; next state IDLE.
//  - Latency, counting from the start-sampling edge:
//    normal path done asserts MB+3 cycles later (26 for default); special path 1 cycle later.
//  - start while busy (including in DONE) is ignored.
//    Back-to-back: the earliest next start is the cycle after done.
//  - result/flags are stable between done pulses; done never asserts on reset release.
// CONFIGURATION
//  FP_MUL_RNE_EN defined:
//   - Round-to-nearest-even using guard bit + sticky OR of the remaining low product bits.
//   - A mantissa carry-out renormalizes: mantissa=0, e+=1, then the overflow check is reapplied.
//   - Latency is unchanged.
//  FP_MUL_RNE_EN undefined: truncation (round toward zero); the guard/sticky logic is not built.
// TESTING
//  1. a=0x3FC00000 (1.5), b=0x40000000 (2.0), start -> done after 26 cycles, result=0x40400000,
//     all flags 0.
//  2. a=0xC0000000 (-2), b=0x40400000 (3) -> result=0xC0C00000. busy=1 for 26 cycles;
//     a start pulse mid-op is ignored.
//  3. Specials (done 1 cycle after start):
//     0x00000000*0x40000000 -> 0x00000000, zero=1.
//     0x7F800000*0x3F800000 -> 0x7FC00000, invalid=1.
//     0x00000001*0x3F800000 -> 0x00000000, zero=1, underflow=1.
//  4. 0x7F000000*0x7F000000 -> 0x7F800000, overflow=1.
//     0x00800000*0x00800000 -> 0x00000000, underflow=1, zero=1.
//  5. 0x3FC00001*0x3FC00001 -> 0x40100001 without FP_MUL_RNE_EN; 0x40100002 with it.
//  6. Drop rst_n at cycle 10 of an operation -> busy/done/result/flags=0 immediately.
//     No done pulse follows. A fresh start after release completes normally.

Source files
------------

// File: rtl/fp_seq_mul.sv
// Iterative shift-add floating-point multiplier, one significand bit per clock.
// Optional round-to-nearest-even selected by defining FP_MUL_RNE_EN (default: truncation).
module fp_seq_mul #(
  parameter int MB = 23,
  parameter int EB = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [MB+EB:0]   a,
  input  logic [MB+EB:0]   b,
  output logic             busy,
  output logic             done,
  output logic [MB+EB:0]   result,
  output logic             invalid,
  output logic             overflow,
  output logic             underflow,
  output logic             zero
);

  localparam int N    = MB + EB + 1;
  localparam int BIAS = 2**(EB-1) - 1;
  localparam int PW   = 2*MB + 2;
  localparam int CW   = $clog2(MB + 2);
  localparam logic signed [EB+1:0] BIAS_E = (EB+2)'(BIAS);
  localparam logic signed [EB+1:0] EMAX_E = (EB+2)'(2**EB - 1);
  localparam logic signed [EB+1:0] ZERO_E = '0;
  localparam logic [CW-1:0]        CNT_INIT = CW'(MB + 1);

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [EB+1:0]   e_q, e_d;
  logic [MB:0]            ma_q, ma_d;
  logic [PW-1:0]          acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [N-1:0]           res_q, res_d;
  logic [3:0]             fl_q, fl_d;      // {invalid, overflow, underflow, zero}
  logic [N-1:0]           result_q;
  logic [3:0]             flags_q;
  logic                   done_q;

  logic [EB-1:0]          a_exp, b_exp;
  logic                   a_den, b_den;
  logic [MB+1:0]          sum;
  logic                   hi;
  logic [MB-1:0]          mant;
  logic signed [EB+1:0]   en;

`ifdef FP_MUL_RNE_EN
  logic [MB:0]            rnd;

  function automatic logic [MB:0] rne(input logic [MB-1:0] m, input logic g, input logic s);
    return {1'b0, m} + (MB+1)'(g & (s | m[0]));
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    e_d     = e_q;
    ma_d    = ma_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    fl_d    = fl_q;

    a_exp = a[N-2:MB];
    b_exp = b[N-2:MB];
    a_den = (a_exp == '0) && (a[MB-1:0] != '0);
    b_den = (b_exp == '0) && (b[MB-1:0] != '0);

    // Add multiplicand into the upper half when the multiplier LSB is set; carry kept for the shift.
    sum  = {1'b0, acc_q[PW-1:MB+1]} + (acc_q[0] ? {1'b0, ma_q} : '0);
    hi   = acc_q[PW-1];
    mant = hi ? acc_q[PW-2:MB+1] : acc_q[PW-3:MB];
    en   = e_q + $signed({{(EB+1){1'b0}}, hi});
`ifdef FP_MUL_RNE_EN
    rnd  = rne(mant, hi ? acc_q[MB] : acc_q[MB-1],
               hi ? |acc_q[MB-1:0] : |acc_q[MB-2:0]);
    mant = rnd[MB-1:0];
    en   = en + $signed({{(EB+1){1'b0}}, rnd[MB]});
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = a[N-1] ^ b[N-1];
          ma_d   = {1'b1, a[MB-1:0]};
          acc_d  = {{(MB+1){1'b0}}, 1'b1, b[MB-1:0]};
          e_d    = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_E;
          cnt_d  = CNT_INIT;
          fl_d   = '0;
          if ((a_exp == '1) || (b_exp == '1)) begin
            res_d   = {1'b0, {EB{1'b1}}, 1'b1, {(MB-1){1'b0}}};
            fl_d    = 4'b1000;
            state_d = DONE;
          end else if ((a_exp == '0) || (b_exp == '0)) begin
            res_d   = {a[N-1] ^ b[N-1], {(N-1){1'b0}}};
            fl_d    = {2'b00, a_den | b_den, 1'b1};
            state_d = DONE;
          end else begin
            state_d = MULT;
          end
        end
      end
      MULT: begin
        acc_d = {sum, acc_q[MB:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = NORM;
      end
      NORM: begin
        res_d = {sign_q, en[EB-1:0], mant};
        fl_d  = '0;
        if (en >= EMAX_E) begin
          res_d = {sign_q, {EB{1'b1}}, {MB{1'b0}}};
          fl_d  = 4'b0100;
        end else if (en <= ZERO_E) begin
          res_d = {sign_q, {(N-1){1'b0}}};
          fl_d  = 4'b0011;
        end
        state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == DONE);
      if (state_q == DONE) begin
        result_q <= res_q;
        flags_q  <= fl_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    e_q    <= e_d;
    ma_q   <= ma_d;
    acc_q  <= acc_d;
    cnt_q  <= cnt_d;
    res_q  <= res_d;
    fl_q   <= fl_d;
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign invalid   = flags_q[3];
  assign overflow  = flags_q[2];
  assign underflow = flags_q[1];
  assign zero      = flags_q[0];

endmodule

// File: tb/tb_fp_seq_mul.sv
// Randomized and directed bench for fp_seq_mul against an arithmetic reference model.
module tb_fp_seq_mul;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, invalid, overflow, underflow, zero;
  logic [31:0] result;

  int n_chk = 0;
  int n_pass = 0;

  fp_seq_mul dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .invalid(invalid), .overflow(overflow), .underflow(underflow), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f);
    int ex, ey, e, sh;
    logic s;
    longint unsigned p, mant;
`ifdef FP_MUL_RNE_EN
    longint unsigned rem, half;
`endif
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    if (ex == 255 || ey == 255) begin
      r = 32'h7FC00000; f = 4'b1000; return;
    end
    if (ex == 0 || ey == 0) begin
      r = {s, 31'd0};
      f = {2'b00, (ex == 0 && x[22:0] != 0) || (ey == 0 && y[22:0] != 0), 1'b1};
      return;
    end
    p = (64'h800000 | 64'(x[22:0])) * (64'h800000 | 64'(y[22:0]));
    e = ex + ey - 127;
    if (p >= 64'h8000_0000_0000) begin sh = 24; e++; end
    else sh = 23;
    mant = (p >> sh) & 64'h7FFFFF;
`ifdef FP_MUL_RNE_EN
    rem  = p & ((64'd1 << sh) - 1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && mant[0])) mant++;
    if (mant == 64'h800000) begin mant = 0; e++; end
`endif
    if (e >= 255) begin r = {s, 8'hFF, 23'd0}; f = 4'b0100; end
    else if (e <= 0) begin r = {s, 31'd0}; f = 4'b0011; end
    else begin r = {s, 8'(e), mant[22:0]}; f = 4'b0000; end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'hFF;
    else if (r < 4)  e = 8'($urandom_range(1, 254));
    else             e = 8'($urandom_range(80, 175));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Drive one operation; mid >= 0 pulses a stray start that many cycles after acceptance.
  task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] er, input logic [3:0] ef, input int elat, input int mid);
    int cyc, busy_n;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cyc = 0; busy_n = 0;
    while (!done && cyc < 200) begin
      if (busy) busy_n++;
      if (cyc == mid) begin start = 1'b1; a = ~ia; b = ib ^ 32'h0040_0000; end
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, ".lat"},   64'(cyc), 64'(elat));
    check({tag, ".busy"},  64'(busy_n), 64'(elat));
    check({tag, ".res"},   64'(result), 64'(er));
    check({tag, ".flags"}, 64'({invalid, overflow, underflow, zero}), 64'(ef));
    @(negedge clk);
    check({tag, ".pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, er;
    logic [3:0]  ef;
    int          seen, lat;

    #1;
    check("rst.busy",   64'(busy), 64'd0);
    check("rst.done",   64'(done), 64'd0);
    check("rst.result", 64'(result), 64'd0);
    check("rst.flags",  64'({invalid, overflow, underflow, zero}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel.done", 64'(done), 64'd0);

    run_op("t1",     32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26, -1);
    run_op("t2",     32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 26, 10);
    run_op("t2end",  32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 26, 25);
    run_op("zero",   32'h00000000, 32'h40000000, 32'h00000000, 4'b0001, 1, -1);
    run_op("nzero",  32'h80000000, 32'h40000000, 32'h80000000, 4'b0001, 1, -1);
    run_op("inf",    32'h7F800000, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, -1);
    run_op("nanz",   32'h00000000, 32'h7FC00000, 32'h7FC00000, 4'b1000, 1, -1);
    run_op("denorm", 32'h00000001, 32'h3F800000, 32'h00000000, 4'b0011, 1, -1);
    run_op("ovf",    32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0100, 26, -1);
    run_op("udf",    32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 26, -1);
`ifdef FP_MUL_RNE_EN
    run_op("round",  32'h3FC00001, 32'h3FC00001, 32'h40100002, 4'b0000, 26, -1);
`else
    run_op("round",  32'h3FC00001, 32'h3FC00001, 32'h40100001, 4'b0000, 26, -1);
`endif

    // Abort an operation with reset part-way through.
    @(negedge clk);
    a = 32'h3FC00000; b = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort.busy",   64'(busy), 64'd0);
    check("abort.done",   64'(done), 64'd0);
    check("abort.result", 64'(result), 64'd0);
    check("abort.flags",  64'({invalid, overflow, underflow, zero}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("abort.nodone", 64'(seen), 64'd0);
    run_op("fresh", 32'hBFC00000, 32'h40000000, 32'hC0400000, 4'b0000, 26, -1);

    repeat (40) begin
      ra = rand_fp();
      rb = rand_fp();
      ref_mul(ra, rb, er, ef);
      lat = (ra[30:23] == 8'hFF || rb[30:23] == 8'hFF ||
             ra[30:23] == 8'h00 || rb[30:23] == 8'h00) ? 1 : 26;
      run_op("rand", ra, rb, er, ef, lat, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
